// File: rtl/screen_fade_ctrl.sv
// Post-mux video fade stage: scales RGB by a frame-synchronous brightness level (fade out / hold / fade in).
// Latency: exactly 1 clk for RGB and syncs; status flags are registered alongside.
// No backpressure: streaming pixel path, fadeRequest while busy is dropped. Optional macro: FADE_HOLD_INPUT_EN.
module screen_fade_ctrl #(
   parameter int LEVEL_BITS      = 4,
   parameter int FRAMES_PER_STEP = 2,
   parameter int HOLD_FRAMES     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startOfFrame,
   input  logic       fadeRequest,
`ifdef FADE_HOLD_INPUT_EN
   input  logic       holdRelease,
`endif
   input  logic [7:0] redIn,
   input  logic [7:0] greenIn,
   input  logic [7:0] blueIn,
   input  logic       hsyncIn,
   input  logic       vsyncIn,
   output logic [7:0] redOut,
   output logic [7:0] greenOut,
   output logic [7:0] blueOut,
   output logic       hsyncOut,
   output logic       vsyncOut,
   output logic       fadeBusy,
   output logic       screenBlack,
   output logic       fadeDone
);

   // Level spans 0..2**LEVEL_BITS inclusive, so it needs one extra bit.
   localparam int LVL_W    = LEVEL_BITS + 1;
   localparam int PROD_W   = 8 + LEVEL_BITS + 1;
   localparam int CNT_W    = 16;
   localparam int STEP_EFF = (FRAMES_PER_STEP < 1) ? 1 : FRAMES_PER_STEP;
   localparam int HOLD_EFF = (HOLD_FRAMES < 1) ? 1 : HOLD_FRAMES;

   localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(1 << LEVEL_BITS);
   localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_EFF - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FADE_OUT = 2'd1,
      ST_HOLD     = 2'd2,
      ST_FADE_IN  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
   logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic              fade_busy_q, fade_busy_d;
   logic              screen_black_q, screen_black_d;
   logic              fade_done_q, fade_done_d;
   logic [7:0]        red_out_q, red_out_d;
   logic [7:0]        green_out_q, green_out_d;
   logic [7:0]        blue_out_q, blue_out_d;
   logic              hsync_q, hsync_d;
   logic              vsync_q, vsync_d;
`ifdef FADE_HOLD_INPUT_EN
   logic              release_q, release_d;
`endif

   // Multiply one 8-bit colour by the level; level MAX is an exact passthrough.
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [LVL_W-1:0] lvl);
      logic [PROD_W-1:0] prod;
      prod = PROD_W'(c) * PROD_W'(lvl);
      return 8'(prod >> LEVEL_BITS);
   endfunction

   // Next-state logic: sequencing of the fade, level stepping only on frame pulses.
   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      step_cnt_d = step_cnt_q;
      hold_cnt_d = hold_cnt_q;
      fade_done_d = 1'b0;
`ifdef FADE_HOLD_INPUT_EN
      release_d  = release_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // A frame pulse coinciding with the request is not a step.
            if (fadeRequest) begin
               state_d    = ST_FADE_OUT;
               step_cnt_d = '0;
               hold_cnt_d = '0;
            end
         end
         ST_FADE_OUT: begin
            if (startOfFrame) begin
               if (step_cnt_q == STEP_LAST) begin
                  step_cnt_d = '0;
                  level_d    = level_q - LVL_ONE;
                  if (level_q == LVL_ONE) begin
                     state_d    = ST_HOLD;
                     hold_cnt_d = '0;
                  end
               end else begin
                  step_cnt_d = step_cnt_q + CNT_ONE;
               end
            end
         end
         ST_HOLD: begin
`ifdef FADE_HOLD_INPUT_EN
            // Release is sticky until the next frame pulse takes us out of HOLD.
            if (holdRelease) begin
               release_d = 1'b1;
            end
            if (startOfFrame) begin
               hold_cnt_d = hold_cnt_q + CNT_ONE;
               if (release_q || holdRelease) begin
                  state_d    = ST_FADE_IN;
                  step_cnt_d = '0;
                  hold_cnt_d = '0;
                  release_d  = 1'b0;
               end
            end
`else
            if (startOfFrame) begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d    = ST_FADE_IN;
                  step_cnt_d = '0;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + CNT_ONE;
               end
            end
`endif
         end
         ST_FADE_IN: begin
            if (startOfFrame) begin
               if (step_cnt_q == STEP_LAST) begin
                  step_cnt_d = '0;
                  level_d    = level_q + LVL_ONE;
                  if (level_q == (LVL_MAX - LVL_ONE)) begin
                     state_d     = ST_IDLE;
                     fade_done_d = 1'b1;
                  end
               end else begin
                  step_cnt_d = step_cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            level_d = LVL_MAX;
         end
      endcase
   end

   // Status flags describe the state/level that will hold after this edge.
   always_comb begin
      fade_busy_d    = (state_d != ST_IDLE);
      screen_black_d = (level_d == '0);
   end

   // Pixel path: scale by the level in force this cycle, syncs delayed to match.
   always_comb begin
      red_out_d   = scale(redIn,   level_q);
      green_out_d = scale(greenIn, level_q);
      blue_out_d  = scale(blueIn,  level_q);
      hsync_d     = hsyncIn;
      vsync_d     = vsyncIn;
   end

   // All state and registered outputs; reset drops any partial fade immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         level_q        <= LVL_MAX;
         step_cnt_q     <= '0;
         hold_cnt_q     <= '0;
         fade_busy_q    <= 1'b0;
         screen_black_q <= 1'b0;
         fade_done_q    <= 1'b0;
         red_out_q      <= '0;
         green_out_q    <= '0;
         blue_out_q     <= '0;
         hsync_q        <= 1'b1;
         vsync_q        <= 1'b1;
`ifdef FADE_HOLD_INPUT_EN
         release_q      <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         level_q        <= level_d;
         step_cnt_q     <= step_cnt_d;
         hold_cnt_q     <= hold_cnt_d;
         fade_busy_q    <= fade_busy_d;
         screen_black_q <= screen_black_d;
         fade_done_q    <= fade_done_d;
         red_out_q      <= red_out_d;
         green_out_q    <= green_out_d;
         blue_out_q     <= blue_out_d;
         hsync_q        <= hsync_d;
         vsync_q        <= vsync_d;
`ifdef FADE_HOLD_INPUT_EN
         release_q      <= release_d;
`endif
      end
   end

   assign redOut      = red_out_q;
   assign greenOut    = green_out_q;
   assign blueOut     = blue_out_q;
   assign hsyncOut    = hsync_q;
   assign vsyncOut    = vsync_q;
   assign fadeBusy    = fade_busy_q;
   assign screenBlack = screen_black_q;
   assign fadeDone    = fade_done_q;

endmodule
